audio_sample_sched: RTL and testbench

Paced sample scheduler between the I2S receiver and the HDMI audio packetizer, all in the audio master clock domain. Buffers incoming stereo sample pairs in a small FIFO and releases them at a fixed AMCLK/PACE_DIV rate over a valid/ready handshake. Handles fill-up, underflow (repeat last), overflow (drop newest), loss of input (timeout to mute) and forced mute, so the downstream packet stream never stalls.

---
 rtl/audio_sched_pkg.sv | 26 ++
 rtl/sample_fifo.sv | 57 +++++
 rtl/audio_sample_sched.sv | 158 +++++++++++++++
 tb/tb_audio_sample_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_sched_pkg
// Brief    : Shared state encodings, default sizes and helpers for the
//            paced audio sample scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package audio_sched_pkg;

    localparam int c_DATA_BITS      = 16;
    localparam int c_FIFO_DEPTH     = 8;
    localparam int c_PACE_DIV       = 16;
    localparam int c_TIMEOUT_CYCLES = 4096;

    localparam int              c_ST_W    = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_FILL = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_RUN  = 2'd2;

    // Level needs one bit more than the address so "full" is representable.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sample_fifo
// Brief    : Synchronous FIFO with flush; pointers carry an extra wrap bit.
// Revision : 1.0 - initial release
// ============================================================================
module sample_fifo
    import audio_sched_pkg::*;
#(
    parameter int WIDTH = 2 * c_DATA_BITS,
    parameter int DEPTH = c_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_flush,
    input  logic                          i_push,
    input  logic [WIDTH-1:0]              i_wdata,
    input  logic                          i_pop,
    output logic [WIDTH-1:0]              o_rdata,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [level_width(DEPTH)-1:0] o_level
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_rdata   = r_mem[r_rd_ptr[c_AW-1:0]];
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/audio_sample_sched.sv
`default_nettype none
// ============================================================================
// Module   : audio_sample_sched
// Brief    : Buffers stereo sample pairs and releases them at AMCLK/PACE_DIV
//            with underflow repeat, overflow drop, input-loss timeout and mute.
// Revision : 1.0 - initial release
// ============================================================================
module audio_sample_sched
    import audio_sched_pkg::*;
#(
    parameter int DATA_BITS      = c_DATA_BITS,
    parameter int FIFO_DEPTH     = c_FIFO_DEPTH,
    parameter int PACE_DIV       = c_PACE_DIV,
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES
) (
    input  logic                                 AMCLK_i,
    input  logic                                 reset_n,
    input  logic signed [DATA_BITS-1:0]          IN_LEFT_i,
    input  logic signed [DATA_BITS-1:0]          IN_RIGHT_i,
    input  logic                                 IN_VALID_i,
    output logic signed [DATA_BITS-1:0]          OUT_LEFT_o,
    output logic signed [DATA_BITS-1:0]          OUT_RIGHT_o,
    output logic                                 OUT_VALID_o,
    input  logic                                 OUT_READY_i,
    input  logic                                 MUTE_i,
    input  logic                                 CLR_STATUS_i,
    output logic                                 LOCKED_o,
    output logic [level_width(FIFO_DEPTH)-1:0]   FIFO_LEVEL_o,
    output logic                                 UNDERFLOW_o,
    output logic                                 OVERFLOW_o,
    output logic                                 SLIP_o
);

    localparam int c_LW = level_width(FIFO_DEPTH);
    localparam int c_PW = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_DW = 2 * DATA_BITS;
    localparam logic [c_PW-1:0] c_PACE_LAST = c_PW'(PACE_DIV - 1);
    localparam logic [c_TW-1:0] c_TO_MAX    = c_TW'(TIMEOUT_CYCLES);
    localparam logic [c_LW-1:0] c_LVL_HALF  = c_LW'(FIFO_DEPTH / 2);

    logic [c_ST_W-1:0] r_state, w_state_nxt;
    logic [c_PW-1:0]   r_pace_cnt;
    logic [c_TW-1:0]   r_idle_cnt;
    logic [c_DW-1:0]   r_last, w_head, w_src;
    logic [c_LW-1:0]   w_level;
    logic              w_full, w_empty;
    logic              w_tick, w_timeout, w_accept, w_slip, w_present;
    logic              w_run_tick, w_pop, w_push, w_underflow, w_overflow;
    logic              r_out_valid, r_underflow, r_overflow, r_slip;
    logic [DATA_BITS-1:0] r_out_l, r_out_r;

    assign w_tick      = (r_pace_cnt == c_PACE_LAST);
    assign w_timeout   = (r_idle_cnt == c_TO_MAX) && (r_state != c_ST_IDLE);
    assign w_accept    = r_out_valid && OUT_READY_i;
    assign w_slip      = w_tick && r_out_valid && !OUT_READY_i;
    assign w_present   = w_tick && !w_slip;
    assign w_run_tick  = w_present && (r_state == c_ST_RUN) && !w_timeout;
    assign w_pop       = w_run_tick && !w_empty;
    assign w_underflow = w_run_tick && w_empty;
    assign w_push      = IN_VALID_i && !w_timeout;
    assign w_overflow  = w_push && w_full && !w_pop;

    sample_fifo #(
        .WIDTH (c_DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (AMCLK_i),
        .rst_n   (reset_n),
        .i_flush (w_timeout),
        .i_push  (w_push),
        .i_wdata ({IN_LEFT_i, IN_RIGHT_i}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    always_ff @(posedge AMCLK_i) begin
        if (!reset_n) begin
            r_pace_cnt <= '0;
            r_state    <= c_ST_IDLE;
        end else begin
            r_pace_cnt <= w_tick ? '0 : r_pace_cnt + 1'b1;
            r_state    <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: if (IN_VALID_i) w_state_nxt = c_ST_FILL;
                c_ST_FILL: if (w_level >= c_LVL_HALF) w_state_nxt = c_ST_RUN;
                c_ST_RUN:  w_state_nxt = c_ST_RUN;
                default:   w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // Saturating count of consecutive cycles without an input strobe.
    always_ff @(posedge AMCLK_i) begin
        if (!reset_n || IN_VALID_i)   r_idle_cnt <= '0;
        else if (r_idle_cnt != c_TO_MAX) r_idle_cnt <= r_idle_cnt + 1'b1;
    end

    // Idle/fill ticks and timeout ticks leave w_src at zero.
    always_comb begin
        w_src = '0;
        if (w_pop)            w_src = w_head;
        else if (w_underflow) w_src = r_last;
    end

    always_ff @(posedge AMCLK_i) begin
        if (!reset_n || w_timeout) r_last <= '0;
        else if (w_pop)            r_last <= w_head;
    end

    always_ff @(posedge AMCLK_i) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_l     <= '0;
            r_out_r     <= '0;
        end else if (w_present) begin
            r_out_valid <= 1'b1;
            r_out_l     <= MUTE_i ? '0 : w_src[c_DW-1:DATA_BITS];
            r_out_r     <= MUTE_i ? '0 : w_src[DATA_BITS-1:0];
        end else if (w_accept) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge AMCLK_i) begin
        if (!reset_n) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
            r_slip      <= 1'b0;
        end else begin
            r_underflow <= w_underflow | (r_underflow & ~CLR_STATUS_i);
            r_overflow  <= w_overflow  | (r_overflow  & ~CLR_STATUS_i);
            r_slip      <= w_slip      | (r_slip      & ~CLR_STATUS_i);
        end
    end

    assign OUT_LEFT_o   = r_out_l;
    assign OUT_RIGHT_o  = r_out_r;
    assign OUT_VALID_o  = r_out_valid;
    assign LOCKED_o     = (r_state == c_ST_RUN);
    assign FIFO_LEVEL_o = w_level;
    assign UNDERFLOW_o  = r_underflow;
    assign OVERFLOW_o   = r_overflow;
    assign SLIP_o       = r_slip;

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_audio_sample_sched
// Brief    : Scenario-driven scoreboard bench for audio_sample_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_sample_sched;
    import audio_sched_pkg::*;

    localparam int c_LW = level_width(c_FIFO_DEPTH);

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [15:0]     in_l = '0, in_r = '0;
    logic            in_valid = 1'b0, out_ready = 1'b1, mute = 1'b0, clr = 1'b0;
    logic [15:0]     out_l, out_r;
    logic            out_valid, locked, uf, of, slip;
    logic [c_LW-1:0] level;

    int          n_checks = 0;
    int          n_err = 0;
    int          idle_run = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_pair = '0;

    always #5 clk = ~clk;

    audio_sample_sched #(
        .DATA_BITS      (c_DATA_BITS),
        .FIFO_DEPTH     (c_FIFO_DEPTH),
        .PACE_DIV       (c_PACE_DIV),
        .TIMEOUT_CYCLES (c_TIMEOUT_CYCLES)
    ) dut (
        .AMCLK_i      (clk),
        .reset_n      (reset_n),
        .IN_LEFT_i    (in_l),
        .IN_RIGHT_i   (in_r),
        .IN_VALID_i   (in_valid),
        .OUT_LEFT_o   (out_l),
        .OUT_RIGHT_o  (out_r),
        .OUT_VALID_o  (out_valid),
        .OUT_READY_i  (out_ready),
        .MUTE_i       (mute),
        .CLR_STATUS_i (clr),
        .LOCKED_o     (locked),
        .FIFO_LEVEL_o (level),
        .UNDERFLOW_o  (uf),
        .OVERFLOW_o   (of),
        .SLIP_o       (slip)
    );

    // Advance one clock; idle_run = edges since the last sampled strobe.
    task automatic step();
        idle_run = in_valid ? 0 : idle_run + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int xfers = 0;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mute = 1'b0; clr = 1'b0;
        repeat (4) step();
        reset_n = 1'b1;
        n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++; if ({out_l, out_r} !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", {out_l, out_r}); end
        n_checks++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b expected 0", locked); end
        n_checks++; if (level !== '0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_checks++; if ({uf, of, slip} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {uf, of, slip}); end
        for (int c = 0; c < 48; c++) begin
            step();
            if (out_valid && out_ready) begin
                xfers++;
                n_checks++; if ({out_l, out_r} !== 32'h0) begin n_err++; $display("FAIL idle_zero: got %h expected 0", {out_l, out_r}); end
            end
        end
        n_checks++; if (xfers != 3) begin n_err++; $display("FAIL idle_pace: got %0d transfers expected 3", xfers); end
        n_checks++; if ({locked, uf, of, slip} !== 4'b0000) begin n_err++; $display("FAIL idle_status: got %b expected 0000", {locked, uf, of, slip}); end
    endtask

    task automatic test_steady();
        int fed = 0, got = 0;
        bit seen = 0;
        logic [31:0] exp_p;
        sb_q.delete();
        out_ready = 1'b1; mute = 1'b0;
        for (int cyc = 0; cyc < 320; cyc++) begin
            step();
            in_valid = (cyc % 16 == 0);
            if (in_valid) begin
                fed++;
                in_l = 16'(fed);
                in_r = 16'(-fed);
                sb_q.push_back({in_l, in_r});
                last_pair = {in_l, in_r};
            end
            if (out_valid && out_ready && (seen || {out_l, out_r} != 32'h0)) begin
                seen = 1;
                exp_p = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
                got++;
                n_checks++; if ({out_l, out_r} !== exp_p) begin n_err++; $display("FAIL steady_order: got %h expected %h", {out_l, out_r}, exp_p); end
            end
        end
        in_valid = 1'b0;
        n_checks++; if (locked !== 1'b1) begin n_err++; $display("FAIL steady_locked: got %b expected 1", locked); end
        n_checks++; if (level < 3 || level > 5) begin n_err++; $display("FAIL steady_level: got %0d expected 3..5", level); end
        n_checks++; if ({uf, of, slip} !== 3'b000) begin n_err++; $display("FAIL steady_flags: got %b expected 000", {uf, of, slip}); end
        n_checks++; if (got < 14) begin n_err++; $display("FAIL steady_count: got %0d pairs expected >=14", got); end
    endtask

    task automatic test_drain_timeout();
        int repeats = 0, drop_idle = -1;
        bit done = 0;
        logic [31:0] exp_p;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4400 && !done; c++) begin
            step();
            if (!locked && drop_idle < 0) drop_idle = idle_run;
            if (out_valid && out_ready) begin
                if (sb_q.size() != 0) begin
                    exp_p = sb_q.pop_front();
                    n_checks++; if ({out_l, out_r} !== exp_p) begin n_err++; $display("FAIL drain_order: got %h expected %h", {out_l, out_r}, exp_p); end
                end else if (locked && idle_run < 4000) begin
                    repeats++;
                    n_checks++; if ({out_l, out_r} !== last_pair) begin n_err++; $display("FAIL underflow_repeat: got %h expected %h", {out_l, out_r}, last_pair); end
                end else if (drop_idle >= 0 && idle_run > drop_idle + 20) begin
                    done = 1;
                    n_checks++; if ({out_l, out_r} !== 32'h0) begin n_err++; $display("FAIL timeout_zero: got %h expected 0", {out_l, out_r}); end
                end
            end
        end
        n_checks++; if (drop_idle < 4096 || drop_idle > 4098) begin n_err++; $display("FAIL timeout_time: got %0d idle cycles expected 4096..4098", drop_idle); end
        n_checks++; if (repeats == 0) begin n_err++; $display("FAIL underflow_seen: got %0d repeats expected >0", repeats); end
        n_checks++; if (uf !== 1'b1) begin n_err++; $display("FAIL underflow_flag: got %b expected 1", uf); end
        n_checks++; if (level !== '0) begin n_err++; $display("FAIL timeout_level: got %0d expected 0", level); end
        n_checks++; if (!done) begin n_err++; $display("FAIL timeout_idle: got no zero pair expected one"); end
    endtask

    task automatic test_overflow();
        int delivered = 0;
        bit started = 0, finished = 0, seen_v = 0;
        logic [31:0] exp_p;
        sb_q.delete();
        clr = 1'b1; step(); clr = 1'b0;
        n_checks++; if ({uf, of, slip} !== 3'b000) begin n_err++; $display("FAIL clear_all: got %b expected 000", {uf, of, slip}); end
        out_ready = 1'b0;
        for (int c = 0; c < 40 && !seen_v; c++) begin step(); seen_v = out_valid; end
        n_checks++; if (!seen_v) begin n_err++; $display("FAIL ovf_wait: got no valid expected valid within 40 cycles"); end
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_l = 16'(16'h0100 + i);
            in_r = 16'(16'h8000 + i);
            if (i <= 8) sb_q.push_back({in_l, in_r});
            step();
        end
        in_valid = 1'b0;
        step();
        n_checks++; if (level !== c_LW'(8)) begin n_err++; $display("FAIL ovf_level: got %0d expected 8", level); end
        n_checks++; if (of !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", of); end
        n_checks++; if (locked !== 1'b1) begin n_err++; $display("FAIL ovf_locked: got %b expected 1", locked); end
        out_ready = 1'b1;
        for (int c = 0; c < 400 && !finished; c++) begin
            step();
            if (out_valid && out_ready && (started || {out_l, out_r} != 32'h0)) begin
                started = 1;
                if (sb_q.size() != 0) begin
                    exp_p = sb_q.pop_front();
                    delivered++;
                    n_checks++; if ({out_l, out_r} !== exp_p) begin n_err++; $display("FAIL ovf_order: got %h expected %h", {out_l, out_r}, exp_p); end
                end else begin
                    finished = 1;
                    n_checks++; if ({out_l, out_r} !== 32'h0108_8008) begin n_err++; $display("FAIL ovf_dropped: got %h expected 01088008", {out_l, out_r}); end
                end
            end
        end
        n_checks++; if (delivered != 8 || !finished) begin n_err++; $display("FAIL ovf_count: got %0d pairs expected 8", delivered); end
    endtask

    task automatic test_slip();
        bit seen_v = 0, changed = 0;
        logic [31:0] held;
        clr = 1'b1; step(); clr = 1'b0;
        n_checks++; if ({of, slip} !== 2'b00) begin n_err++; $display("FAIL clr_flags: got %b expected 00", {of, slip}); end
        out_ready = 1'b0;
        for (int c = 0; c < 40 && !seen_v; c++) begin step(); seen_v = out_valid; end
        held = {out_l, out_r};
        n_checks++; if (!seen_v || held !== 32'h0108_8008) begin n_err++; $display("FAIL slip_data: got %h expected 01088008", held); end
        for (int c = 0; c < 40; c++) begin
            step();
            if (!out_valid || {out_l, out_r} !== held) changed = 1;
        end
        n_checks++; if (changed) begin n_err++; $display("FAIL slip_hold: got %h expected %h", {out_l, out_r}, held); end
        n_checks++; if (slip !== 1'b1) begin n_err++; $display("FAIL slip_flag: got %b expected 1", slip); end
        out_ready = 1'b1;
        step(); step();
        clr = 1'b1; step(); clr = 1'b0;
        n_checks++; if ({of, slip} !== 2'b00) begin n_err++; $display("FAIL slip_clear: got %b expected 00", {of, slip}); end
    endtask

    task automatic test_mute();
        int seen = 0;
        logic [15:0] neg_l;
        mute = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 128; cyc++) begin
            step();
            in_valid = (cyc % 16 == 0);
            if (in_valid) begin
                in_l = 16'(16'h0200 + cyc / 16 + 1);
                in_r = 16'(~in_l + 16'd1);
            end
            if (cyc >= 20 && out_valid && out_ready) begin
                n_checks++; if ({out_l, out_r} !== 32'h0) begin n_err++; $display("FAIL mute_zero: got %h expected 0", {out_l, out_r}); end
            end
        end
        n_checks++; if (locked !== 1'b1 || level > 2) begin n_err++; $display("FAIL mute_level: got locked %b level %0d expected 1 and <=2", locked, level); end
        mute = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            step();
            in_valid = (cyc % 16 == 0);
            if (in_valid) begin
                in_l = 16'(16'h0209 + cyc / 16);
                in_r = 16'(~in_l + 16'd1);
            end
            if (cyc >= 20 && out_valid && out_ready) begin
                seen++;
                neg_l = 16'(~out_l + 16'd1);
                n_checks++;
                if (out_r !== neg_l || out_l < 16'h0201 || out_l > 16'h020D) begin
                    n_err++; $display("FAIL unmute_pair: got %h/%h expected fed pair", out_l, out_r);
                end
            end
        end
        in_valid = 1'b0;
        n_checks++; if (seen == 0) begin n_err++; $display("FAIL unmute_seen: got 0 pairs expected >0"); end
    endtask

    task automatic test_reset_midop();
        bit seen_v = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_l = 16'(16'h0300 + i); in_r = 16'(16'h0400 + i);
            step();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 40 && !seen_v; c++) begin step(); seen_v = out_valid; end
        n_checks++; if (!seen_v || level < 2) begin n_err++; $display("FAIL midop_pre: got valid %b level %0d expected 1 and >=2", seen_v, level); end
        reset_n = 1'b0; step(); reset_n = 1'b1;
        n_checks++; if ({out_valid, locked, uf, of, slip} !== 5'b0 || level !== '0 || {out_l, out_r} !== 32'h0) begin
            n_err++; $display("FAIL midop_reset: got vld %b lck %b flags %b lvl %0d data %h expected all 0",
                              out_valid, locked, {uf, of, slip}, level, {out_l, out_r});
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_drain_timeout();
        test_overflow();
        test_slip();
        test_mute();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
